alu_be_comp: RTL and testbench

ALU_BE_COMP -- requirements
Module: alu_be_comp

---
 rtl/alu_be_comp.sv | 127 ++++++++++++
 tb/tb_alu_be_comp.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_be_comp.sv
// alu_be_comp: single-cycle ALU, branch comparator and byte-enable generator.
// All outputs are registered one edge after a valid input cycle and hold
// their values while in_valid is low. Reset is synchronous and active-low.
// Define ALU_BE_COMP_OVF_EN to add the registered signed-overflow output ovf.
module alu_be_comp (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [3:0]  alu_ctrl,
  input  logic [2:0]  comp_op,
  input  logic        is_lb_sb,
  input  logic        is_lh_sh,
  output logic        out_valid,
  output logic [31:0] alu_out,
  output logic        comp_out,
  output logic [3:0]  be_out
`ifdef ALU_BE_COMP_OVF_EN
  ,
  output logic        ovf
`endif
);

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 5;
  localparam int unsigned BW = 4;

  logic [DW-1:0] sum_c;
  logic [DW-1:0] diff_c;
  logic [SW-1:0] shamt_c;
  logic [DW-1:0] alu_res_c;
  logic          comp_res_c;
  logic [BW-1:0] be_res_c;
  logic          a_zero_c;

  assign sum_c    = src_a + src_b;
  assign diff_c   = src_a - src_b;
  assign shamt_c  = src_a[SW-1:0];
  assign a_zero_c = (src_a == '0);

  // ALU result selection
  always_comb begin
    alu_res_c = '0;
    case (alu_ctrl)
      4'd0:    alu_res_c = sum_c;
      4'd1:    alu_res_c = diff_c;
      4'd2:    alu_res_c = src_a & src_b;
      4'd3:    alu_res_c = src_a | src_b;
      4'd4:    alu_res_c = src_a ^ src_b;
      4'd5:    alu_res_c = ~(src_a | src_b);
      4'd6:    alu_res_c = DW'($signed(src_a) < $signed(src_b));
      4'd7:    alu_res_c = DW'(src_a < src_b);
      4'd8:    alu_res_c = src_b << shamt_c;
      4'd9:    alu_res_c = src_b >> shamt_c;
      4'd10:   alu_res_c = DW'($signed(src_b) >>> shamt_c);
      4'd11:   alu_res_c = {src_b[15:0], 16'h0000};
      4'd12:   alu_res_c = src_b;
      default: alu_res_c = '0;
    endcase
  end

  // Branch comparison; sign tests look only at operand A
  always_comb begin
    comp_res_c = 1'b0;
    case (comp_op)
      3'd0:    comp_res_c = (src_a == src_b);
      3'd1:    comp_res_c = (src_a != src_b);
      3'd2:    comp_res_c = src_a[DW-1] | a_zero_c;
      3'd3:    comp_res_c = ~src_a[DW-1] & ~a_zero_c;
      3'd4:    comp_res_c = src_a[DW-1];
      3'd5:    comp_res_c = ~src_a[DW-1];
      default: comp_res_c = 1'b0;
    endcase
  end

  // Byte enables from the low address bits of the ALU result; byte wins over halfword
  always_comb begin
    be_res_c = 4'b1111;
    if (is_lb_sb) begin
      be_res_c = 4'b0001 << alu_res_c[1:0];
    end else if (is_lh_sh) begin
      be_res_c = alu_res_c[1] ? 4'b1100 : 4'b0011;
    end
  end

`ifdef ALU_BE_COMP_OVF_EN
  logic ovf_res_c;

  // Signed overflow for add and subtract only
  always_comb begin
    ovf_res_c = 1'b0;
    if (alu_ctrl == 4'd0) begin
      ovf_res_c = (src_a[DW-1] == src_b[DW-1]) && (sum_c[DW-1] != src_a[DW-1]);
    end else if (alu_ctrl == 4'd1) begin
      ovf_res_c = (src_a[DW-1] != src_b[DW-1]) && (diff_c[DW-1] != src_a[DW-1]);
    end
  end

  // Overflow register, same hold rules as the other results
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= ovf_res_c;
    end
  end
`endif

  // Output registers: capture on valid, hold otherwise
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      alu_out   <= '0;
      comp_out  <= 1'b0;
      be_out    <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        alu_out  <= alu_res_c;
        comp_out <= comp_res_c;
        be_out   <= be_res_c;
      end
    end
  end

endmodule

// File: tb/tb_alu_be_comp.sv
// Directed self-checking bench for alu_be_comp.
module tb_alu_be_comp;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [3:0]  alu_ctrl;
  logic [2:0]  comp_op;
  logic        is_lb_sb;
  logic        is_lh_sh;
  logic        out_valid;
  logic [31:0] alu_out;
  logic        comp_out;
  logic [3:0]  be_out;
`ifdef ALU_BE_COMP_OVF_EN
  logic        ovf;
`endif

  int checks;
  int failures;

  alu_be_comp dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .src_a    (src_a),
    .src_b    (src_b),
    .alu_ctrl (alu_ctrl),
    .comp_op  (comp_op),
    .is_lb_sb (is_lb_sb),
    .is_lh_sh (is_lh_sh),
    .out_valid(out_valid),
    .alu_out  (alu_out),
    .comp_out (comp_out),
    .be_out   (be_out)
`ifdef ALU_BE_COMP_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs, clock it, sample 1 time unit after the edge
  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] c, input logic [2:0] op,
                       input logic lb, input logic lh);
    in_valid = v;
    src_a    = a;
    src_b    = b;
    alu_ctrl = c;
    comp_op  = op;
    is_lb_sb = lb;
    is_lh_sh = lh;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b1, 32'd5, 32'd3, 4'd0, 3'd0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || alu_out !== 32'd0 || comp_out !== 1'b0 || be_out !== 4'b0000) begin
      $display("FAIL reset_clear: valid=%b alu=%h comp=%b be=%b expected all zero",
               out_valid, alu_out, comp_out, be_out);
      failures++;
    end
`ifdef ALU_BE_COMP_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin $display("FAIL reset_ovf: got %b expected 0", ovf); failures++; end
`endif
    rst = 1'b1;
    drive(1'b1, 32'd5, 32'd3, 4'd0, 3'd0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || alu_out !== 32'd8 || be_out !== 4'b1111 || comp_out !== 1'b0) begin
      $display("FAIL first_result: valid=%b alu=%h be=%b comp=%b expected 1 00000008 1111 0",
               out_valid, alu_out, be_out, comp_out);
      failures++;
    end
  endtask

  task automatic test_alu_logic();
    logic [3:0]  ctrl [7];
    logic [31:0] exp  [7];
    ctrl = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd12, 4'd13};
    exp  = '{32'h00E0_100E, 32'h00F0_000F, 32'hFFF0_0FFF, 32'hFF00_0FF0,
             32'h000F_F000, 32'h0FF0_0F0F, 32'h0000_0000};
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 32'hF0F0_00FF, 32'h0FF0_0F0F, ctrl[i], 3'd0, 1'b0, 1'b0);
      checks++;
      if (alu_out !== exp[i]) begin
        $display("FAIL alu_ctrl_%0d: got %h expected %h", ctrl[i], alu_out, exp[i]);
        failures++;
      end
    end
    drive(1'b1, 32'd5, 32'd3, 4'd1, 3'd0, 1'b0, 1'b0);
    checks++;
    if (alu_out !== 32'd2) begin $display("FAIL sub: got %h expected 2", alu_out); failures++; end
    drive(1'b1, 32'd0, 32'd1, 4'd1, 3'd0, 1'b0, 1'b0);
    checks++;
    if (alu_out !== 32'hFFFF_FFFF) begin $display("FAIL sub_wrap: got %h expected ffffffff", alu_out); failures++; end
  endtask

  task automatic test_slt_ovf();
    drive(1'b1, 32'hFFFF_FFFF, 32'd1, 4'd6, 3'd0, 1'b0, 1'b0);
    checks++;
    if (alu_out !== 32'd1) begin $display("FAIL slt_signed: got %h expected 1", alu_out); failures++; end
    drive(1'b1, 32'hFFFF_FFFF, 32'd1, 4'd7, 3'd0, 1'b0, 1'b0);
    checks++;
    if (alu_out !== 32'd0) begin $display("FAIL slt_unsigned: got %h expected 0", alu_out); failures++; end
    drive(1'b1, 32'hFFFF_FFFF, 32'd1, 4'd0, 3'd0, 1'b0, 1'b0);
    checks++;
    if (alu_out !== 32'd0) begin $display("FAIL add_wrap: got %h expected 0", alu_out); failures++; end
`ifdef ALU_BE_COMP_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin $display("FAIL ovf_wrap: got %b expected 0", ovf); failures++; end
`endif
    drive(1'b1, 32'h7FFF_FFFF, 32'd1, 4'd0, 3'd0, 1'b0, 1'b0);
    checks++;
    if (alu_out !== 32'h8000_0000) begin $display("FAIL add_ovf: got %h expected 80000000", alu_out); failures++; end
`ifdef ALU_BE_COMP_OVF_EN
    checks++;
    if (ovf !== 1'b1) begin $display("FAIL ovf_add: got %b expected 1", ovf); failures++; end
    drive(1'b1, 32'h8000_0000, 32'd1, 4'd1, 3'd0, 1'b0, 1'b0);
    checks++;
    if (ovf !== 1'b1) begin $display("FAIL ovf_sub: got %b expected 1", ovf); failures++; end
`endif
  endtask

  task automatic test_shifts();
    drive(1'b1, 32'd4, 32'h8000_0000, 4'd8, 3'd0, 1'b0, 1'b0);
    checks++;
    if (alu_out !== 32'd0) begin $display("FAIL sll: got %h expected 0", alu_out); failures++; end
    drive(1'b1, 32'd4, 32'h8000_0000, 4'd9, 3'd0, 1'b0, 1'b0);
    checks++;
    if (alu_out !== 32'h0800_0000) begin $display("FAIL srl: got %h expected 08000000", alu_out); failures++; end
    drive(1'b1, 32'd4, 32'h8000_0000, 4'd10, 3'd0, 1'b0, 1'b0);
    checks++;
    if (alu_out !== 32'hF800_0000) begin $display("FAIL sra: got %h expected f8000000", alu_out); failures++; end
    drive(1'b1, 32'd4, 32'h0000_1234, 4'd11, 3'd0, 1'b0, 1'b0);
    checks++;
    if (alu_out !== 32'h1234_0000) begin $display("FAIL lui: got %h expected 12340000", alu_out); failures++; end
    drive(1'b1, 32'hFFFF_FFE4, 32'd1, 4'd8, 3'd0, 1'b0, 1'b0);
    checks++;
    if (alu_out !== 32'd16) begin $display("FAIL sll_shamt5: got %h expected 10", alu_out); failures++; end
  endtask

  task automatic test_byte_enable();
    logic [31:0] bv   [7];
    logic        lbv  [7];
    logic        lhv  [7];
    logic [3:0]  expb [7];
    bv   = '{32'd1, 32'd2, 32'd3, 32'd2, 32'd3, 32'd1, 32'd3};
    lbv  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    lhv  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    expb = '{4'b0010, 4'b0100, 4'b1000, 4'b1100, 4'b1000, 4'b0011, 4'b1111};
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 32'h1000, bv[i], 4'd0, 3'd0, lbv[i], lhv[i]);
      checks++;
      if (be_out !== expb[i]) begin
        $display("FAIL be_case_%0d: got %b expected %b", i, be_out, expb[i]);
        failures++;
      end
    end
  endtask

  task automatic test_compare();
    logic [31:0] av  [11];
    logic [31:0] bv  [11];
    logic [2:0]  opv [11];
    logic        exc [11];
    av  = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd7};
    bv  = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
            32'd0, 32'd0, 32'd0, 32'd5, 32'd7};
    opv = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};
    exc = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, av[i], bv[i], 4'd12, opv[i], 1'b0, 1'b0);
      checks++;
      if (comp_out !== exc[i]) begin
        $display("FAIL comp_case_%0d_op%0d: got %b expected %b", i, opv[i], comp_out, exc[i]);
        failures++;
      end
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 32'h1000, 32'd1, 4'd0, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'(i * 7 + 3), 32'(i + 9), 4'(i + 2), 3'd1, 1'b0, 1'b1);
      checks++;
      if (out_valid !== 1'b0 || alu_out !== 32'h1001 || comp_out !== 1'b0 || be_out !== 4'b0010) begin
        $display("FAIL hold_%0d: valid=%b alu=%h comp=%b be=%b expected 0 00001001 0 0010",
                 i, out_valid, alu_out, comp_out, be_out);
        failures++;
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'd10, 32'd20, 4'd0, 3'd1, 1'b0, 1'b0);
    checks++;
    if (alu_out !== 32'd30 || comp_out !== 1'b1 || out_valid !== 1'b1) begin
      $display("FAIL b2b_0: alu=%h comp=%b valid=%b expected 0000001e 1 1", alu_out, comp_out, out_valid);
      failures++;
    end
    drive(1'b1, 32'd20, 32'd10, 4'd1, 3'd0, 1'b0, 1'b1);
    checks++;
    if (alu_out !== 32'd10 || comp_out !== 1'b0 || be_out !== 4'b1100 || out_valid !== 1'b1) begin
      $display("FAIL b2b_1: alu=%h comp=%b be=%b valid=%b expected 0000000a 0 1100 1",
               alu_out, comp_out, be_out, out_valid);
      failures++;
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 32'h1000, 32'd3, 4'd0, 3'd0, 1'b1, 1'b0);
    rst = 1'b0;
    drive(1'b1, 32'h55, 32'h55, 4'd0, 3'd0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || alu_out !== 32'd0 || comp_out !== 1'b0 || be_out !== 4'b0000) begin
      $display("FAIL mid_reset: valid=%b alu=%h comp=%b be=%b expected all zero",
               out_valid, alu_out, comp_out, be_out);
      failures++;
    end
    rst = 1'b1;
    drive(1'b0, 32'h55, 32'h55, 4'd0, 3'd0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || alu_out !== 32'd0 || comp_out !== 1'b0 || be_out !== 4'b0000) begin
      $display("FAIL post_reset_idle: valid=%b alu=%h comp=%b be=%b expected all zero",
               out_valid, alu_out, comp_out, be_out);
      failures++;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    in_valid = 1'b0;
    src_a    = '0;
    src_b    = '0;
    alu_ctrl = '0;
    comp_op  = '0;
    is_lb_sb = 1'b0;
    is_lh_sh = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_alu_logic();
    test_slt_ovf();
    test_shifts();
    test_byte_enable();
    test_compare();
    test_hold();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
